// File: rtl/gf256_pow_seq.sv
// GF(2^8) exponentiation sequencer.
// Computes base^exp with MSB-first square-and-multiply over one shared
// combinational multiplier, or base^254 (the multiplicative inverse) when
// inv is set. One product is formed per cycle.
// Field polynomial: x^8 + x^4 + x^3 + x^2 + 1 (0x11D).

// Mastrovito-style multiplier: p = M(a) * b, where column j of M is
// a * x^j already reduced modulo the field polynomial.
module gf256_poly_mult_mastrovito (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  // Low byte of the field polynomial. The x^8 term is implied.
  localparam logic [7:0] POLY_LO = 8'h1D;

  logic [7:0][7:0] col;

  // Build the reduced columns a*x^j by repeated xtime.
  always_comb begin
    col = '0;
    col[0] = a;
    for (int j = 1; j < 8; j++) begin
      col[j] = {col[j-1][6:0], 1'b0} ^ (col[j-1][7] ? POLY_LO : 8'h00);
    end
  end

  // Matrix-vector product over GF(2): XOR of the columns selected by b.
  always_comb begin
    p = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) p = p ^ col[j];
    end
  end

endmodule

module gf256_pow_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       inv,
  input  logic [7:0] base,
  input  logic [7:0] exp,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Exponent that yields the inverse in GF(2^8): x^254 = x^-1.
  localparam logic [7:0] INV_EXP = 8'd254;

  state_t     state_q, state_d;
  logic [7:0] base_r_q, base_r_d;
  logic [7:0] exp_r_q, exp_r_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] result_q, result_d;

  logic [7:0] mul_a, mul_b, prod;

  // The multiplier squares acc in SQR and multiplies acc by base in MUL.
  assign mul_a = acc_q;
  assign mul_b = (state_q == S_SQR) ? acc_q : base_r_q;

  gf256_poly_mult_mastrovito u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_r_q  <= 8'h00;
      exp_r_q   <= 8'h00;
      acc_q     <= 8'h01;
      bit_idx_q <= 3'd0;
      result_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      base_r_q  <= base_r_d;
      exp_r_q   <= exp_r_d;
      acc_q     <= acc_d;
      bit_idx_q <= bit_idx_d;
      result_q  <= result_d;
    end
  end

  // Next-state and datapath control for the square-and-multiply walk.
  always_comb begin
    state_d   = state_q;
    base_r_d  = base_r_q;
    exp_r_d   = exp_r_q;
    acc_d     = acc_q;
    bit_idx_d = bit_idx_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        // Requests are only honoured here; start while busy is dropped.
        if (start) begin
          base_r_d  = base;
          exp_r_d   = inv ? INV_EXP : exp;
          acc_d     = 8'h01;
          bit_idx_d = 3'd7;
          state_d   = S_SQR;
        end
      end

      S_SQR: begin
        acc_d = prod;
        if (exp_r_q[bit_idx_q]) begin
          // Multiply step for this bit follows; keep the index.
          state_d = S_MUL;
        end else if (bit_idx_q == 3'd0) begin
          result_d = prod;
          state_d  = S_DONE;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end
      end

      S_MUL: begin
        acc_d = prod;
        if (bit_idx_q == 3'd0) begin
          result_d = prod;
          state_d  = S_DONE;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
          state_d   = S_SQR;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode registered state only, so they do not glitch.
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_gf256_pow_seq.sv
// Bench for gf256_pow_seq: a cycle-level behavioural model (operation
// length 8+popcount, result from repeated field multiplication) compared
// every cycle, plus directed cases with literal expectations.
module tb_gf256_pow_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       inv = 1'b0;
  logic [7:0] base = 8'h00;
  logic [7:0] exp = 8'h00;
  logic       busy, done;
  logic [7:0] result;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  gf256_pow_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .inv    (inv),
    .base   (base),
    .exp    (exp),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Carry-less product followed by long division by 0x11D.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] c;
    logic [14:0] poly;
    c = 15'h0;
    poly = 15'h11D;
    for (int i = 0; i < 8; i++) if (y[i]) c = c ^ (15'(x) << i);
    for (int i = 14; i >= 8; i--) if (c[i]) c = c ^ (poly << (i - 8));
    return c[7:0];
  endfunction

  // x^e as e successive multiplications by x.
  function automatic logic [7:0] gf_pow(input logic [7:0] x, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, x);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
  endtask

  // Behavioural model: an accepted request completes 8+popcount edges later.
  logic       m_busy = 1'b0, m_done = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_pend = 8'h00, m_result = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_result <= 8'h00;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 8 + $countones(inv ? 8'd254 : exp);
        m_pend <= gf_pow(base, int'(inv ? 8'd254 : exp));
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (m_cnt == 1) begin
      m_done <= 1'b1; m_result <= m_pend; m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(m_result));
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One operation; checks result and accept-to-done latency.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic iv,
                        input logic [7:0] exp_res, input int exp_lat, input string nm,
                        output logic [7:0] got);
    int lat;
    wait_idle();
    base = b; exp = e; inv = iv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    base = ~b; exp = ~e; inv = ~iv;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (done !== 1'b1 && lat < 40);
    got = result;
    chk({nm, "_res"}, 32'(result), 32'(exp_res));
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [7:0] got;
  logic [7:0] rb, re;
  logic       ri;
  int         busy_cnt;

  initial begin
    // Pin the model with hand-computed values for 0x11D.
    chk("model_mul_2_80", 32'(gf_mul(8'h02, 8'h80)), 32'h1D);
    chk("model_pow_2_8", 32'(gf_pow(8'h02, 8)), 32'h1D);
    chk("model_pow_2_255", 32'(gf_pow(8'h02, 255)), 32'h01);
    chk("model_pow_0_0", 32'(gf_pow(8'h00, 0)), 32'h01);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'h00);

    // 2^7 = 0x80, 11 cycles; busy spans 12 cycles.
    wait_idle();
    base = 8'h02; exp = 8'h07; inv = 1'b0; start = 1'b1;
    busy_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      if (done === 1'b1) chk("b2e7_res", 32'(result), 32'h80);
      @(negedge clk);
    end
    chk("b2e7_busy_len", 32'(busy_cnt), 32'd12);
    run_op(8'h02, 8'h07, 1'b0, 8'h80, 11, "b2e7", got);

    run_op(8'h00, 8'h00, 1'b0, 8'h01, 8, "b0e0", got);
    run_op(8'h00, 8'h05, 1'b0, 8'h00, 10, "b0e5", got);
    run_op(8'h07, 8'hFF, 1'b0, gf_pow(8'h07, 255), 16, "b7eff", got);
    run_op(8'h01, 8'h3C, 1'b1, 8'h01, 15, "inv1", got);
    run_op(8'h00, 8'h3C, 1'b1, 8'h00, 15, "inv0", got);

    // Inverse of every nonzero element.
    for (int b = 1; b < 256; b++) begin
      run_op(8'(b), 8'h3C, 1'b1, gf_pow(8'(b), 254), 15, "inv", got);
      chk("inv_prod", 32'(gf_mul(8'(b), got)), 32'h01);
    end

    // start held high with operands changing every cycle.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      base = 8'($urandom); exp = 8'($urandom); inv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset four cycles into a long operation.
    base = 8'h53; exp = 8'hFF; inv = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'h00);
    reset = 1'b0;
    run_op(8'h02, 8'h01, 1'b0, 8'h02, 9, "after_rst", got);

    // Random triples.
    for (int i = 0; i < 2000; i++) begin
      rb = 8'($urandom); re = 8'($urandom); ri = ($urandom_range(0, 7) == 0);
      run_op(rb, re, ri, gf_pow(rb, int'(ri ? 8'd254 : re)),
             8 + $countones(ri ? 8'd254 : re), "rand", got);
    end

    wait_idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
